freq_meter: RTL

Measures the frequency of an external test signal against the board's 50 MHz clock and presents the result as six packed BCD digits for the seven-segment display path. It is the counterpart of the clock divider. The divider derives slow clocks from `clk_50mhz`; this block takes an unknown slow signal and counts its rising edges over a fixed gate window timed by `clk_50mhz`. It sits between the pin/divider outputs and the display scanner.

---
 rtl/freq_meter_pkg.sv | 17 +
 rtl/bcd_digit.sv | 28 ++
 rtl/freq_meter.sv | 115 +++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: gate FSM encoding and BCD digit helpers.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        GATE  = 2'd0,
        LATCH = 2'd1,
        CLEAR = 2'd2
    } gate_state_e;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

    function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
        return (d == BCD_NINE) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD event counter; carry ripples to the next decade on 9 -> 0.
module bcd_digit
    import freq_meter_pkg::*;
(
    input  logic               clk_50mhz,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic [DIGIT_W-1:0] q_q;

    always_ff @(posedge clk_50mhz) begin
        if (!rst) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (inc) begin
            q_q <= bcd_inc(q_q);
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q == BCD_NINE);

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a fixed gate window of clk_50mhz cycles and
// presents the last completed count as packed BCD with a sticky full-scale flag.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int DIGITS      = 6
) (
    input  logic                      clk_50mhz,
    input  logic                      rst,
    input  logic                      sig_in,
    output logic [DIGIT_W*DIGITS-1:0] freq_bcd,
    output logic                      ovf,
    output logic                      valid
);

    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    logic                      sync1_q, sync2_q, prev_q;
    gate_state_e               state_q;
    logic [GW-1:0]             gcnt_q;
    logic                      ovf_sticky_q;
    logic [DIGIT_W*DIGITS-1:0] freq_q;
    logic                      ovf_q;
    logic                      valid_q;

    logic                      rise;
    logic                      in_gate;
    logic                      all_nines;
    logic                      cnt_inc;
    logic                      cnt_clr;
    logic [DIGITS-1:0]         is_nine;
    logic [DIGITS-1:0]         inc_w;
    logic [DIGITS-1:0]         carry_w;
    logic [DIGIT_W*DIGITS-1:0] cnt_w;
    logic                      carry_unused;

    assign rise      = sync2_q & ~prev_q;
    assign in_gate   = (state_q == GATE);
    assign all_nines = &is_nine;
    // Once full scale is reached the digits hold; further rises only set the sticky flag.
    assign cnt_inc   = rise & in_gate & ~all_nines;
    assign cnt_clr   = (state_q == CLEAR);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign inc_w[i] = cnt_inc;
        end else begin : g_upper
            assign inc_w[i] = carry_w[i-1];
        end

        bcd_digit u_digit (
            .clk_50mhz (clk_50mhz),
            .rst       (rst),
            .clr       (cnt_clr),
            .inc       (inc_w[i]),
            .q         (cnt_w[i*DIGIT_W +: DIGIT_W]),
            .carry     (carry_w[i])
        );

        assign is_nine[i] = (cnt_w[i*DIGIT_W +: DIGIT_W] == BCD_NINE);
    end

    assign carry_unused = carry_w[DIGITS-1];

    always_ff @(posedge clk_50mhz) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            state_q      <= CLEAR;
            gcnt_q       <= '0;
            ovf_sticky_q <= 1'b0;
            freq_q       <= '0;
            ovf_q        <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
            case (state_q)
                GATE: begin
                    gcnt_q <= gcnt_q + 1'b1;
                    if (rise && all_nines) begin
                        ovf_sticky_q <= 1'b1;
                    end
                    if (gcnt_q == GATE_LAST) begin
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    freq_q  <= cnt_w;
                    ovf_q   <= ovf_sticky_q;
                    valid_q <= 1'b1;
                    state_q <= CLEAR;
                end
                CLEAR: begin
                    gcnt_q       <= '0;
                    ovf_sticky_q <= 1'b0;
                    state_q      <= GATE;
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign freq_bcd = freq_q;
    assign ovf      = ovf_q;
    assign valid    = valid_q;

endmodule
